// File: rtl/nios_cpu_qsys_timer_master.sv
// nios_cpu_qsys_timer_master
// Avalon-MM master that programs and services an interval-timer slave.
// Starts the timer with a period and mode, clears timeouts as they are
// raised, takes register snapshots on request, and stops the timer.
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   cfg_start           pulse: program period/mode and start the timer
//   cfg_period          32-bit period, sampled with cfg_start
//   cfg_continuous      continuous-mode bit, sampled with cfg_start
//   stop_req            pulse: stop the timer
//   snap_req            pulse: capture and read the snapshot registers
//   timer_irq           timeout level from the timer slave
//   avm_*               Avalon-MM master (read latency 1)
//   busy                high while a bus sequence is in progress
//   running             high between the start control write and the stop write
//   tick, tick_count    pulse and wrapping count of serviced timeouts
//   snap_value/_valid   last snapshot and its one-cycle update strobe
module nios_cpu_qsys_timer_master #(
  parameter int unsigned TICK_W  = 16,
  parameter logic        CTL_ITO = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_start,
  input  logic [31:0]       cfg_period,
  input  logic              cfg_continuous,
  input  logic              stop_req,
  input  logic              snap_req,
  input  logic              timer_irq,
  output logic [2:0]        avm_address,
  output logic              avm_chipselect,
  output logic              avm_write_n,
  output logic [15:0]       avm_writedata,
  input  logic [15:0]       avm_readdata,
  output logic              busy,
  output logic              running,
  output logic              tick,
  output logic [TICK_W-1:0] tick_count,
  output logic [31:0]       snap_value,
  output logic              snap_valid
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_PL,
    S_WR_PH,
    S_WR_CTL,
    S_RUN,
    S_CLR_TO,
    S_WR_SNAP,
    S_RD_SNL,
    S_RD_SNH,
    S_SN_CAP,
    S_WR_STOP
  } state_e;

  state_e              state_q, state_d;

  logic                pend_start_q, pend_start_d;
  logic                pend_stop_q,  pend_stop_d;
  logic                pend_snap_q,  pend_snap_d;
  logic [31:0]         pend_period_q, pend_period_d;
  logic                pend_cont_q,   pend_cont_d;

  logic [31:0]         period_q, period_d;
  logic                cont_q,   cont_d;
  logic                running_q, running_d;
  logic [TICK_W-1:0]   tick_count_q, tick_count_d;
  logic [15:0]         snap_lo_q, snap_lo_d;
  logic [31:0]         snap_value_q, snap_value_d;
  logic                snap_valid_q, snap_valid_d;

  // A request seen this cycle counts as pending immediately, so requests
  // arriving in IDLE/RUN are served without a latching delay.
  logic                start_eff, stop_eff, snap_eff;
  logic                take_start, take_stop, take_snap;
  logic                at_rest;

  always_comb begin
    start_eff = pend_start_q | cfg_start;
    stop_eff  = pend_stop_q  | stop_req;
    snap_eff  = pend_snap_q  | snap_req;
    at_rest   = (state_q == S_IDLE) || (state_q == S_RUN);
  end

  always_comb begin
    state_d        = state_q;
    avm_chipselect = 1'b0;
    avm_write_n    = 1'b1;
    avm_address    = '0;
    avm_writedata  = '0;
    tick           = 1'b0;
    take_start     = 1'b0;
    take_stop      = 1'b0;
    take_snap      = 1'b0;

    unique case (state_q)
      S_IDLE, S_RUN: begin
        if (stop_eff) begin
          take_stop = 1'b1;
          state_d   = S_WR_STOP;
        end else if (start_eff) begin
          take_start = 1'b1;
          state_d    = S_WR_PL;
        end else if ((state_q == S_RUN) && timer_irq) begin
          state_d = S_CLR_TO;
        end else if (snap_eff) begin
          take_snap = 1'b1;
          state_d   = S_WR_SNAP;
        end
      end
      S_WR_PL: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = 3'd2;
        avm_writedata  = period_q[15:0];
        state_d        = S_WR_PH;
      end
      S_WR_PH: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = 3'd3;
        avm_writedata  = period_q[31:16];
        state_d        = S_WR_CTL;
      end
      S_WR_CTL: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = 3'd1;
        avm_writedata  = {12'b0, 1'b0, 1'b1, cont_q, CTL_ITO};
        state_d        = S_RUN;
      end
      S_CLR_TO: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = 3'd0;
        tick           = 1'b1;
        state_d        = S_RUN;
      end
      S_WR_SNAP: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = 3'd4;
        state_d        = S_RD_SNL;
      end
      S_RD_SNL: begin
        avm_chipselect = 1'b1;
        avm_address    = 3'd4;
        state_d        = S_RD_SNH;
      end
      S_RD_SNH: begin
        avm_chipselect = 1'b1;
        avm_address    = 3'd5;
        state_d        = S_SN_CAP;
      end
      S_SN_CAP: begin
        // running is set exactly while the rest state is RUN, so it
        // doubles as the record of where the snapshot was launched from.
        state_d = running_q ? S_RUN : S_IDLE;
      end
      S_WR_STOP: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = 3'd1;
        avm_writedata  = 16'h0008;
        state_d        = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pend_start_d  = start_eff & ~take_start;
    pend_stop_d   = stop_eff  & ~take_stop;
    pend_snap_d   = snap_eff  & ~take_snap;
    pend_period_d = cfg_start ? cfg_period     : pend_period_q;
    pend_cont_d   = cfg_start ? cfg_continuous : pend_cont_q;

    period_d = period_q;
    cont_d   = cont_q;
    if (take_start) begin
      period_d = pend_period_d;
      cont_d   = pend_cont_d;
    end

    running_d = running_q;
    if (state_q == S_WR_CTL)  running_d = 1'b1;
    if (state_q == S_WR_STOP) running_d = 1'b0;

    tick_count_d = tick_count_q;
    if (state_q == S_CLR_TO) tick_count_d = tick_count_q + TICK_W'(1);

    snap_lo_d = snap_lo_q;
    if (state_q == S_RD_SNH) snap_lo_d = avm_readdata;

    snap_value_d = snap_value_q;
    snap_valid_d = 1'b0;
    if (state_q == S_SN_CAP) begin
      snap_value_d = {avm_readdata, snap_lo_q};
      snap_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      pend_start_q  <= 1'b0;
      pend_stop_q   <= 1'b0;
      pend_snap_q   <= 1'b0;
      pend_period_q <= '0;
      pend_cont_q   <= 1'b0;
      period_q      <= '0;
      cont_q        <= 1'b0;
      running_q     <= 1'b0;
      tick_count_q  <= '0;
      snap_lo_q     <= '0;
      snap_value_q  <= '0;
      snap_valid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      pend_start_q  <= pend_start_d;
      pend_stop_q   <= pend_stop_d;
      pend_snap_q   <= pend_snap_d;
      pend_period_q <= pend_period_d;
      pend_cont_q   <= pend_cont_d;
      period_q      <= period_d;
      cont_q        <= cont_d;
      running_q     <= running_d;
      tick_count_q  <= tick_count_d;
      snap_lo_q     <= snap_lo_d;
      snap_value_q  <= snap_value_d;
      snap_valid_q  <= snap_valid_d;
    end
  end

  assign busy       = ~at_rest;
  assign running    = running_q;
  assign tick_count = tick_count_q;
  assign snap_value = snap_value_q;
  assign snap_valid = snap_valid_q;

endmodule
